// File: rtl/data_mem_responder.sv
// Word-addressed data memory behind a valid/ready load/store port with a fixed
// number of wait states per access and RV32I byte/halfword/word access widths.
module data_mem_responder #(
    parameter int DEPTH_WORDS = 32,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic [1:0]  dbg_state
);
    // Handshakes: a transfer happens on a rising edge where valid && ready are both
    // high; once raised, rsp_valid and its payload hold until that edge.
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);
    localparam logic [3:0]  WAIT_INIT = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t      r_state, w_state_next;
    logic [3:0]  r_cnt, w_cnt_next;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr, r_wdata;
    logic        r_rsp_valid, r_rsp_err;
    logic [31:0] r_rsp_rdata;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic          w_accept, w_access, w_f3_ok, w_misalign, w_err;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word, w_shift, w_load, w_store_word;
    logic [15:0]   w_half;

    assign req_ready = (r_state == S_IDLE) && !rst;
    assign w_accept  = req_valid && req_ready;
    assign w_access  = (r_state == S_WAIT) && (r_cnt == 4'd0);
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign dbg_state = r_state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            S_IDLE: if (w_accept) begin
                w_state_next = S_WAIT;
                w_cnt_next   = WAIT_INIT;
            end
            S_WAIT: begin
                if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
                else               w_state_next = S_RESP;
            end
            S_RESP:  if (rsp_ready) w_state_next = S_IDLE;
            default: w_state_next = S_IDLE;
        endcase
    end

    // Out-of-range addresses still index a real word; the error flag blocks its use.
    assign w_idx  = r_addr[AW+1:2];
    assign w_word = r_mem[w_idx];

    always_comb begin
        w_f3_ok      = r_we ? (r_funct3 inside {3'b000, 3'b001, 3'b010})
                            : (r_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        w_misalign   = ((r_funct3[1:0] == 2'b01) && r_addr[0]) ||
                       ((r_funct3[1:0] == 2'b10) && (r_addr[1:0] != 2'b00));
        w_err        = !w_f3_ok || w_misalign || (r_addr >= MEM_BYTES);
        w_shift      = w_word >> {r_addr[1:0], 3'b000};
        w_half       = r_addr[1] ? w_word[31:16] : w_word[15:0];
        w_load       = 32'd0;
        w_store_word = w_word;
        case (r_funct3)
            3'b000:  w_load = {{24{w_shift[7]}}, w_shift[7:0]};
            3'b001:  w_load = {{16{w_half[15]}}, w_half};
            3'b010:  w_load = w_word;
            3'b100:  w_load = {24'd0, w_shift[7:0]};
            3'b101:  w_load = {16'd0, w_half};
            default: w_load = 32'd0;
        endcase
        case (r_funct3)
            3'b000:  w_store_word[{r_addr[1:0], 3'b000} +: 8] = r_wdata[7:0];
            3'b001:  w_store_word[{r_addr[1], 4'b0000} +: 16] = r_wdata[15:0];
            3'b010:  w_store_word = r_wdata;
            default: w_store_word = w_word;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we        <= 1'b0;
            r_funct3    <= 3'd0;
            r_addr      <= 32'd0;
            r_wdata     <= 32'd0;
            r_rsp_valid <= 1'b0;
            r_rsp_err   <= 1'b0;
            r_rsp_rdata <= 32'd0;
            for (int i = 0; i < DEPTH_WORDS; i++) r_mem[i] <= 32'd0;
        end else begin
            if (w_accept) begin
                r_we     <= req_we;
                r_funct3 <= req_funct3;
                r_addr   <= req_addr;
                r_wdata  <= req_wdata;
            end
            if (w_access) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || r_we) ? 32'd0 : w_load;
                if (r_we && !w_err) r_mem[w_idx] <= w_store_word;
            end else if ((r_state == S_RESP) && rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end
endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 32, meaning number of 32-bit data words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning extra wait-state cycles per access (0..15).
REQ-003 SHALL have port clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_valid  input  1  load/store request present.
REQ-006 SHALL have port req_ready  output  1  responder can accept a request.
REQ-007 SHALL have port req_we  input  1  1 = store, 0 = load.
REQ-008 SHALL have port req_funct3  input  3  RV32I width code: load 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU; store 000 SB, 001 SH, 010 SW.
REQ-009 SHALL have port req_addr  input  32  byte address.
REQ-010 SHALL have port req_wdata  input  32  store data, right-aligned.
REQ-011 SHALL have port rsp_valid  output  1  response present.
REQ-012 SHALL have port rsp_ready  input  1  requester accepts response.
REQ-013 SHALL have port rsp_rdata  output  32  load result, extended to 32 bits.
REQ-014 SHALL have port rsp_err  output  1  access rejected.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RESP; req_ready = 1 only in IDLE with rst low.
REQ-016 SHALL accept a request on an edge where req_valid && req_ready, capturing we, funct3, addr, wdata, loading wait counter with WAIT_CYCLES, and entering WAIT.
REQ-017 In WAIT, SHALL decrement the counter each cycle while nonzero; when zero, SHALL perform the access on that edge and enter RESP.
REQ-018 rsp_valid SHALL rise exactly WAIT_CYCLES+1 cycles after the accept edge (3 cycles at default).
REQ-019 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL stay stable until rsp_valid && rsp_ready; on that edge SHALL return to IDLE and clear rsp_valid.
REQ-020 Request inputs SHALL be ignored outside IDLE; the earliest next accept is the cycle after the response handshake.
REQ-021 Word index SHALL be addr[log2(DEPTH_WORDS)+1:2]; storage is little-endian (byte 0 = bits 7:0).
REQ-022 rsp_err SHALL be 1 when addr >= 4*DEPTH_WORDS, halfword with addr[0]=1, word with addr[1:0]!=0, or funct3 not listed for the given req_we.
REQ-023 On error, memory SHALL be unchanged and rsp_rdata = 0.
REQ-024 SB SHALL write wdata[7:0] to byte addr[1:0]; SH SHALL write wdata[15:0] to halfword addr[1]; SW SHALL write all 32 bits; unselected bytes SHALL be unchanged.
REQ-025 Store responses SHALL return rsp_rdata = 0, rsp_err = 0.
REQ-026 LB/LH SHALL sign-extend the selected byte/halfword; LBU/LHU SHALL zero-extend; LW returns the word.
REQ-027 With WAIT_CYCLES = 0, the access SHALL occur on the first WAIT edge (latency 1 cycle).

Reset
REQ-028 On rst assertion, SHALL asynchronously force state IDLE, counter 0, rsp_valid 0, rsp_rdata 0, rsp_err 0, and all memory words 0.
REQ-029 Reset mid-WAIT SHALL abort the access; a pending store SHALL NOT modify memory.
REQ-030 req_ready SHALL be 0 while rst is high and 1 in the first cycle after release.

Verification
REQ-031 SW 0xDEADBEEF @0x08, then LW @0x08 -> rsp_rdata 0xDEADBEEF, rsp_err 0, rsp_valid 3 cycles after each accept.
REQ-032 SW 0x11223344 @0x0C, SB 0x80 @0x0D; LW @0x0C -> 0x11228044; LB @0x0D -> 0xFFFFFF80; LBU @0x0D -> 0x00000080; LH @0x0E -> 0x00001122.
REQ-033 LH @0x03 -> err 1, rdata 0; SW 0xFFFFFFFF @0x80 (DEPTH 32) -> err 1, then LW @0x00 still 0; load funct3 011 -> err 1.
REQ-034 rsp_ready held low 5 cycles -> rsp_valid/rdata/err stable, req_ready 0, concurrent req_valid not accepted; accepted cycle after handshake.
REQ-035 Assert rst during WAIT of SW 0x55 @0x10 -> rsp_valid 0 immediately, req_ready 1 after release, LW @0x10 -> 0x00000000.
